// File: rtl/decodificador_teclado_pkg.sv
// Shared types and key codes for the keypad digit producer.
// Internal key codes: 0-9 digits, A '*', B '#', C-F the letter keys.
package decodificador_teclado_pkg;

  localparam int MAX_DIGITS = 20;

  localparam logic [3:0] DIGITO_VAZIO    = 4'hF;
  localparam logic [3:0] TECLA_ASTERISCO = 4'hA;
  localparam logic [3:0] TECLA_HASH      = 4'hB;
  localparam logic [3:0] TECLA_LETRA_MIN = 4'hC;
  localparam logic [3:0] TECLA_LETRA_MAX = 4'hF;

  typedef logic [MAX_DIGITS-1:0][3:0] senhaPac_t;

  localparam senhaPac_t SENHA_VAZIA = {MAX_DIGITS{DIGITO_VAZIO}};

  function automatic logic uma_coluna(input logic [3:0] col);
    return $countones(~col) == 1;
  endfunction

  // col carries exactly one low bit when this is called; bit 0 is the leftmost column.
  function automatic logic [3:0] mapa_tecla(input logic [1:0] lin, input logic [3:0] col);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!col[i]) c = 2'(i);
    case ({lin, c})
      4'b00_00: return 4'h1;
      4'b00_01: return 4'h2;
      4'b00_10: return 4'h3;
      4'b00_11: return TECLA_LETRA_MIN;
      4'b01_00: return 4'h4;
      4'b01_01: return 4'h5;
      4'b01_10: return 4'h6;
      4'b01_11: return 4'hD;
      4'b10_00: return 4'h7;
      4'b10_01: return 4'h8;
      4'b10_10: return 4'h9;
      4'b10_11: return 4'hE;
      4'b11_00: return TECLA_ASTERISCO;
      4'b11_01: return 4'h0;
      4'b11_10: return TECLA_HASH;
      default:  return TECLA_LETRA_MAX;
    endcase
  endfunction

endpackage

// File: rtl/decodificador_teclado_if.sv
// Keypad pins plus the digit handoff towards operacional.
// master is the keypad decoder, slave the keypad/operacional side.
interface decodificador_teclado_if;
  import decodificador_teclado_pkg::*;

  logic       teclado_en;
  logic [3:0] col_matriz;
  logic [3:0] lin_matriz;
  senhaPac_t  digitos_value;
  logic       digitos_valid;

  modport master (
    input  teclado_en, col_matriz,
    output lin_matriz, digitos_value, digitos_valid
  );

  modport slave (
    output teclado_en, col_matriz,
    input  lin_matriz, digitos_value, digitos_valid
  );

endinterface

// File: rtl/decodificador_teclado_varredura.sv
// Row scanner, press/release debounce and key map for the 4x4 keypad.
// Emits a one-cycle o_tecla_pulse with the key code when a press is accepted.
module varredura_teclado
  import decodificador_teclado_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [3:0] i_col,
  output logic [3:0] o_lin,
  output logic [3:0] o_tecla_code,
  output logic       o_tecla_pulse,
  output logic       o_ocupado
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  logic [1:0]        r_estado;
  logic [1:0]        r_linha;
  logic [SCAN_W-1:0] r_cnt_scan;
  logic [DEB_W-1:0]  r_cnt_deb;
  logic [3:0]        r_padrao;
  logic              r_ativo;
  logic [3:0]        r_code;
  logic              r_pulse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado   <= ST_SCAN;
      r_linha    <= 2'd0;
      r_cnt_scan <= '0;
      r_cnt_deb  <= '0;
      r_padrao   <= 4'hF;
      r_ativo    <= 1'b0;
      r_code     <= DIGITO_VAZIO;
      r_pulse    <= 1'b0;
    end else begin
      r_ativo <= i_en;
      r_pulse <= 1'b0;
      // The first enabled cycle only arms the scan so row 0 gets a full window.
      if (!i_en || !r_ativo) begin
        r_estado   <= ST_SCAN;
        r_linha    <= 2'd0;
        r_cnt_scan <= '0;
        r_cnt_deb  <= '0;
        r_padrao   <= 4'hF;
      end else begin
        case (r_estado)
          ST_SCAN: begin
            if (uma_coluna(i_col)) begin
              r_padrao   <= i_col;
              r_estado   <= ST_DEBOUNCE;
              r_cnt_deb  <= '0;
              r_cnt_scan <= '0;
            end else if (r_cnt_scan == SCAN_W'(SCAN_CYCLES - 1)) begin
              r_cnt_scan <= '0;
              r_linha    <= r_linha + 2'd1;
            end else begin
              r_cnt_scan <= r_cnt_scan + 1'b1;
            end
          end
          ST_DEBOUNCE: begin
            if (i_col != r_padrao) begin
              r_estado  <= ST_SCAN;
              r_cnt_deb <= '0;
            end else if (r_cnt_deb == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
              r_estado  <= ST_HOLD;
              r_cnt_deb <= '0;
              r_code    <= mapa_tecla(r_linha, r_padrao);
              r_pulse   <= 1'b1;
            end else begin
              r_cnt_deb <= r_cnt_deb + 1'b1;
            end
          end
          ST_HOLD: begin
            if (i_col != 4'hF) begin
              r_cnt_deb <= '0;
            end else if (r_cnt_deb == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
              r_estado  <= ST_SCAN;
              r_cnt_deb <= '0;
            end else begin
              r_cnt_deb <= r_cnt_deb + 1'b1;
            end
          end
          default: r_estado <= ST_SCAN;
        endcase
      end
    end
  end

  assign o_lin         = r_ativo ? ~(4'b0001 << r_linha) : 4'hF;
  assign o_tecla_code  = r_code;
  assign o_tecla_pulse = r_pulse;
  assign o_ocupado     = (r_estado != ST_SCAN);

endmodule

// File: rtl/decodificador_teclado.sv
// Keypad digit producer: accumulates debounced digits and hands the sequence
// to operacional on '#', with '*' clear, idle timeout and enable gating.
module decodificador_teclado
  import decodificador_teclado_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int TIMEOUT_CYCLES  = 5000000,
  parameter int MAX_DIGITS      = 20
) (
  input logic                     clk,
  input logic                     rst,
  decodificador_teclado_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0] w_tecla_code;
  logic       w_tecla_pulse;
  logic       w_ocupado;
  logic [3:0] w_lin;

  senhaPac_t       r_buffer;
  senhaPac_t       r_value;
  logic            r_valid;
  logic [TO_W-1:0] r_timeout;

  varredura_teclado #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_varredura (
    .clk          (clk),
    .rst          (rst),
    .i_en         (bus.teclado_en),
    .i_col        (bus.col_matriz),
    .o_lin        (w_lin),
    .o_tecla_code (w_tecla_code),
    .o_tecla_pulse(w_tecla_pulse),
    .o_ocupado    (w_ocupado)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buffer  <= SENHA_VAZIA;
      r_value   <= SENHA_VAZIA;
      r_valid   <= 1'b0;
      r_timeout <= '0;
    end else begin
      r_valid <= 1'b0;
      if (!bus.teclado_en) begin
        r_buffer  <= SENHA_VAZIA;
        r_timeout <= '0;
      end else if (w_tecla_pulse) begin
        // A digit beats a same-cycle timeout: the counter never runs during HOLD.
        if (w_tecla_code <= 4'h9) begin
          r_buffer  <= {r_buffer[MAX_DIGITS-2:0], w_tecla_code};
          r_timeout <= '0;
        end else if (w_tecla_code == TECLA_HASH) begin
          r_value   <= r_buffer;
          r_valid   <= 1'b1;
          r_buffer  <= SENHA_VAZIA;
          r_timeout <= '0;
        end else if (w_tecla_code == TECLA_ASTERISCO) begin
          r_buffer  <= SENHA_VAZIA;
          r_timeout <= '0;
        end
      end else if (r_buffer[0] != DIGITO_VAZIO && !w_ocupado) begin
        if (r_timeout == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_buffer  <= SENHA_VAZIA;
          r_timeout <= '0;
        end else begin
          r_timeout <= r_timeout + 1'b1;
        end
      end
    end
  end

  assign bus.lin_matriz    = w_lin;
  assign bus.digitos_value = r_value;
  assign bus.digitos_valid = r_valid;

endmodule
